// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for decode, write-back and the regfile itself.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One architectural register word as seen on the debug taps
  typedef logic [WORD_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_shadow.sv
// Shadow bank for the debug taps: tracks the live registers and holds them while frozen.
module regfile_shadow
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = REG_COUNT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic [NREGS-1:0][WIDTH-1:0] live,
  output logic [NREGS-1:0][WIDTH-1:0] taps
);

  logic [NREGS-1:0][WIDTH-1:0] shadow;

  // Snapshot the committed registers every edge unless frozen; entry 0 only ever loads 0
  always_ff @(posedge clk) begin
    if (rst)          shadow <= '0;
    else if (!freeze) shadow <= live;
  end

  // Unfreezing switches straight to live state, so there is no stale cycle
  always_comb begin
    taps = freeze ? shadow : live;
  end

endmodule

// File: rtl/regfile_bank.sv
// MIPS GPR file: 2 combinational read ports with write bypass, 1 write port,
// $0 hardwired to zero, freezable per-register debug taps and a registered display readout.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data,
  output logic [WIDTH-1:0]  regfiles0,  output logic [WIDTH-1:0] regfiles1,
  output logic [WIDTH-1:0]  regfiles2,  output logic [WIDTH-1:0] regfiles3,
  output logic [WIDTH-1:0]  regfiles4,  output logic [WIDTH-1:0] regfiles5,
  output logic [WIDTH-1:0]  regfiles6,  output logic [WIDTH-1:0] regfiles7,
  output logic [WIDTH-1:0]  regfiles8,  output logic [WIDTH-1:0] regfiles9,
  output logic [WIDTH-1:0]  regfiles10, output logic [WIDTH-1:0] regfiles11,
  output logic [WIDTH-1:0]  regfiles12, output logic [WIDTH-1:0] regfiles13,
  output logic [WIDTH-1:0]  regfiles14, output logic [WIDTH-1:0] regfiles15,
  output logic [WIDTH-1:0]  regfiles16, output logic [WIDTH-1:0] regfiles17,
  output logic [WIDTH-1:0]  regfiles18, output logic [WIDTH-1:0] regfiles19,
  output logic [WIDTH-1:0]  regfiles20, output logic [WIDTH-1:0] regfiles21,
  output logic [WIDTH-1:0]  regfiles22, output logic [WIDTH-1:0] regfiles23,
  output logic [WIDTH-1:0]  regfiles24, output logic [WIDTH-1:0] regfiles25,
  output logic [WIDTH-1:0]  regfiles26, output logic [WIDTH-1:0] regfiles27,
  output logic [WIDTH-1:0]  regfiles28, output logic [WIDTH-1:0] regfiles29,
  output logic [WIDTH-1:0]  regfiles30, output logic [WIDTH-1:0] regfiles31
);

  localparam int NREGS = 2 ** ADDR_W;

  // Storage exists only for 1..NREGS-1; $0 is synthesised as a constant
  logic [WIDTH-1:0]            mem [1:NREGS-1];
  logic [NREGS-1:0][WIDTH-1:0] live;
  logic [NREGS-1:0][WIDTH-1:0] taps;

  // Commit writes; reset wins over a simultaneous write, writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < NREGS; k++) mem[k] <= '0;
    end else if (we && waddr != ZERO_REG) begin
      mem[waddr] <= wdata;
    end
  end

  // Committed view of the whole file, $0 included, without bypass
  always_comb begin
    live[0] = '0;
    for (int k = 1; k < NREGS; k++) live[k] = mem[k];
  end

  // Read ports: $0 first, then same-cycle write bypass, then committed state
  always_comb begin
    rdata1 = live[raddr1];
    rdata2 = live[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == ZERO_REG)    rdata1 = '0;
    if (raddr2 == ZERO_REG)    rdata2 = '0;
  end

  // Display readout samples committed state, ignoring freeze and bypass
  always_ff @(posedge clk) begin
    if (rst) dbg_data <= '0;
    else     dbg_data <= live[dbg_sel];
  end

  regfile_shadow #(.WIDTH(WIDTH), .NREGS(NREGS)) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .live   (live),
    .taps   (taps)
  );

  assign regfiles0  = taps[0];  assign regfiles1  = taps[1];
  assign regfiles2  = taps[2];  assign regfiles3  = taps[3];
  assign regfiles4  = taps[4];  assign regfiles5  = taps[5];
  assign regfiles6  = taps[6];  assign regfiles7  = taps[7];
  assign regfiles8  = taps[8];  assign regfiles9  = taps[9];
  assign regfiles10 = taps[10]; assign regfiles11 = taps[11];
  assign regfiles12 = taps[12]; assign regfiles13 = taps[13];
  assign regfiles14 = taps[14]; assign regfiles15 = taps[15];
  assign regfiles16 = taps[16]; assign regfiles17 = taps[17];
  assign regfiles18 = taps[18]; assign regfiles19 = taps[19];
  assign regfiles20 = taps[20]; assign regfiles21 = taps[21];
  assign regfiles22 = taps[22]; assign regfiles23 = taps[23];
  assign regfiles24 = taps[24]; assign regfiles25 = taps[25];
  assign regfiles26 = taps[26]; assign regfiles27 = taps[27];
  assign regfiles28 = taps[28]; assign regfiles29 = taps[29];
  assign regfiles30 = taps[30]; assign regfiles31 = taps[31];

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: reset, bypass, $0, dual read, freeze and reset-with-write.
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr, dbg_sel;
  logic [31:0] rdata1, rdata2, wdata, dbg_data;
  logic        we, freeze;
  logic [31:0] taps [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bank dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .freeze(freeze), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .regfiles0(taps[0]),   .regfiles1(taps[1]),   .regfiles2(taps[2]),   .regfiles3(taps[3]),
    .regfiles4(taps[4]),   .regfiles5(taps[5]),   .regfiles6(taps[6]),   .regfiles7(taps[7]),
    .regfiles8(taps[8]),   .regfiles9(taps[9]),   .regfiles10(taps[10]), .regfiles11(taps[11]),
    .regfiles12(taps[12]), .regfiles13(taps[13]), .regfiles14(taps[14]), .regfiles15(taps[15]),
    .regfiles16(taps[16]), .regfiles17(taps[17]), .regfiles18(taps[18]), .regfiles19(taps[19]),
    .regfiles20(taps[20]), .regfiles21(taps[21]), .regfiles22(taps[22]), .regfiles23(taps[23]),
    .regfiles24(taps[24]), .regfiles25(taps[25]), .regfiles26(taps[26]), .regfiles27(taps[27]),
    .regfiles28(taps[28]), .regfiles29(taps[29]), .regfiles30(taps[30]), .regfiles31(taps[31])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then apply a write (or idle) for this cycle
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; waddr = a; wdata = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; freeze = 1'b0; dbg_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 5'd0, 32'h0);

    // Reset state across the whole file
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
      chk($sformatf("rst_rd1_%0d", a), rdata1, 32'h0);
      chk($sformatf("rst_rd2_%0d", a), rdata2, 32'h0);
      chk($sformatf("rst_tap_%0d", a), taps[a], 32'h0);
    end
    chk("rst_dbg", dbg_data, 32'h0);

    // Write $5 with same-cycle bypass, then tap and display latency
    raddr1 = 5'd5; dbg_sel = 5'd5;
    cyc(1'b1, 5'd5, 32'hDEADBEEF);
    chk("w5_bypass", rdata1, 32'hDEADBEEF);
    chk("w5_tap_pre", taps[5], 32'h0);
    cyc(1'b0, 5'd0, 32'h0);
    chk("w5_tap", taps[5], 32'hDEADBEEF);
    chk("w5_rd_arr", rdata1, 32'hDEADBEEF);
    chk("w5_dbg_1cyc", dbg_data, 32'h0);
    cyc(1'b0, 5'd0, 32'h0);
    chk("w5_dbg_2cyc", dbg_data, 32'hDEADBEEF);

    // $0 ignores writes, including in the write cycle
    raddr1 = 5'd0; raddr2 = 5'd0; dbg_sel = 5'd0;
    cyc(1'b1, 5'd0, 32'hFFFFFFFF);
    chk("z_rd1_wc", rdata1, 32'h0);
    chk("z_rd2_wc", rdata2, 32'h0);
    chk("z_tap_wc", taps[0], 32'h0);
    cyc(1'b0, 5'd0, 32'h0);
    chk("z_rd1", rdata1, 32'h0);
    chk("z_tap", taps[0], 32'h0);
    cyc(1'b0, 5'd0, 32'h0);
    chk("z_dbg", dbg_data, 32'h0);

    // Dual read of one register, with and without bypass
    cyc(1'b1, 5'd7, 32'h11111111);
    raddr1 = 5'd7; raddr2 = 5'd7;
    cyc(1'b1, 5'd8, 32'hCAFEF00D);
    chk("dual_old_rd1", rdata1, 32'h11111111);
    chk("dual_old_rd2", rdata2, 32'h11111111);
    cyc(1'b1, 5'd7, 32'h12345678);
    chk("dual_byp_rd1", rdata1, 32'h12345678);
    chk("dual_byp_rd2", rdata2, 32'h12345678);
    cyc(1'b0, 5'd0, 32'h0);
    chk("dual_tap7", taps[7], 32'h12345678);
    chk("dual_tap8", taps[8], 32'hCAFEF00D);

    // Freeze holds taps while writes continue; unfreeze is immediate
    cyc(1'b1, 5'd3, 32'h1);
    cyc(1'b0, 5'd0, 32'h0);
    raddr1 = 5'd3;
    @(negedge clk);
    freeze = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h2; #1;
    chk("frz_tap_wc", taps[3], 32'h1);
    chk("frz_rd_wc", rdata1, 32'h2);
    cyc(1'b0, 5'd0, 32'h0);
    chk("frz_tap", taps[3], 32'h1);
    chk("frz_rd", rdata1, 32'h2);
    chk("frz_tap5", taps[5], 32'hDEADBEEF);
    @(negedge clk);
    freeze = 1'b0; #1;
    chk("unfrz_tap", taps[3], 32'h2);

    // Reset while frozen and writing: write lost, shadow cleared
    cyc(1'b1, 5'd9, 32'h00000077);
    cyc(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    freeze = 1'b1; #1;
    chk("rr_tap9_pre", taps[9], 32'h00000077);
    raddr1 = 5'd9;
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; #1;
    chk("rr_bypass", rdata1, 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; dbg_sel = 5'd5; #1;
    chk("rr_rd9", rdata1, 32'h0);
    chk("rr_tap9", taps[9], 32'h0);
    chk("rr_tap5", taps[5], 32'h0);
    chk("rr_dbg", dbg_data, 32'h0);
    @(negedge clk);
    freeze = 1'b0; #1;
    chk("rr_tap9_live", taps[9], 32'h0);
    chk("rr_tap3_live", taps[3], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
